// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Holds the FSM state encoding, the row/column key map and small decode helpers.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  // KEYMAP[row][col], index 0 = bit 0 of row/col
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  function automatic logic [3:0] row_drive(input logic [1:0] ri);
    logic [3:0] one_hot;
    one_hot = 4'b0001 << ri;
    return ~one_hot;
  endfunction

  // Lowest-index active-low column wins when several are pressed together.
  function automatic logic [1:0] low_col(input logic [3:0] c);
    logic [1:0] idx;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Four-bit two-flop synchronizer for the asynchronous column sense lines.
// Resets to all ones so an idle (pulled-up) keypad is seen during reset.
module sync2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low row drive, debounces press
// and release, and emits one key_valid pulse with the hex code per press.
//
// state    | meaning
// SCAN     | rotate rows, sample columns on the last dwell cycle of each row
// DEBOUNCE | row frozen, require a stable low on the latched column
// HELD     | key accepted, all other keys ignored until the column goes high
// RELEASE  | require a stable high before resuming the scan at the next row
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 240000,
  parameter int DEBOUNCE_CYCLES = 480000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam int CW = $clog2((SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    col_s;
  kp_state_t     state;
  logic [1:0]    ri;
  logic [1:0]    ci;
  logic [CW-1:0] scan_cnt;
  logic [CW-1:0] db_cnt;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (col),
    .q     (col_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SCAN;
      ri          <= 2'd0;
      ci          <= 2'd0;
      scan_cnt    <= '0;
      db_cnt      <= '0;
      row         <= 4'b1110;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (col_s != 4'hF) begin
              ci     <= low_col(col_s);
              db_cnt <= '0;
              state  <= DEBOUNCE;
            end else begin
              ri  <= ri + 2'd1;
              row <= row_drive(ri + 2'd1);
            end
          end else begin
            scan_cnt <= scan_cnt + CW'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s[ci]) begin
            ri    <= ri + 2'd1;
            row   <= row_drive(ri + 2'd1);
            state <= SCAN;
          end else if (db_cnt == DB_LAST) begin
            key_code    <= KEYMAP[ri][ci];
            key_valid   <= 1'b1;
            key_pressed <= 1'b1;
            state       <= HELD;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        HELD: begin
          if (col_s[ci]) begin
            db_cnt <= '0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          // A low here is contact bounce on release: fall back without a new pulse.
          if (!col_s[ci]) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            ri          <= ri + 2'd1;
            row         <= row_drive(ri + 2'd1);
            key_pressed <= 1'b0;
            state       <= SCAN;
          end else begin
            db_cnt <= db_cnt + CW'(1);
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational 4x4 keypad model.
// Table-driven single presses plus hand-written bounce, two-key and reset sequences.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic [3:0] keys [4];
  logic       force_zero = 1'b0;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int consec = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    int         r;
    int         c;
    int         hold;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [7];

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .reset       (reset),
    .row         (row),
    .col         (col),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_pressed (key_pressed)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column: column goes low only while that row is driven.
  always_comb begin
    col = 4'hF;
    if (force_zero) col = 4'h0;
    else
      for (int r = 0; r < 4; r++)
        if (row[r] == 1'b0) col = col & ~keys[r];
  end

  always @(posedge clk) begin
    if (key_valid) pulses++;
    if (key_valid && prev_valid) consec++;
    prev_valid = key_valid;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (key_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_release(input int budget, output int cyc);
    cyc = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!key_pressed) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_release(input string name, input int cyc);
    checks++;
    if (cyc < 10 || cyc > 12) begin
      errors++;
      $display("FAIL %s: key_pressed fell after %0d cycles, required 10..12", name, cyc);
    end
  endtask

  initial begin
    int cyc;
    int rc;
    int kp_drop;
    logic [3:0] er;

    for (int r = 0; r < 4; r++) keys[r] = 4'h0;
    vecs[0] = '{2, 1, 40, 4'h8};
    vecs[1] = '{3, 1, 20, 4'h0};
    vecs[2] = '{3, 0, 20, 4'hE};
    vecs[3] = '{3, 2, 20, 4'hF};
    vecs[4] = '{0, 3, 20, 4'hA};
    vecs[5] = '{2, 2, 20, 4'h9};
    vecs[6] = '{1, 3, 20, 4'hB};

    // Reset state with all columns pulled low
    force_zero = 1'b1;
    reset = 1'b0;
    tick(3);
    check("reset_row", row, 4'b1110);
    check("reset_code", key_code, 4'h0);
    check("reset_valid", key_valid, 1'b0);
    check("reset_pressed", key_pressed, 1'b0);
    force_zero = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      er = 4'b0001 << ((k / 4) % 4);
      er = ~er;
      check($sformatf("rotate_%0d", k), row, er);
    end

    // Single clean presses, one per table entry
    for (int v = 0; v < 7; v++) begin
      pulses = 0;
      keys[vecs[v].r] = 4'b0001 << vecs[v].c;
      wait_valid(100, cyc);
      check($sformatf("vec%0d_seen", v), (cyc >= 0), 1'b1);
      check($sformatf("vec%0d_code", v), key_code, vecs[v].exp);
      check($sformatf("vec%0d_pressed", v), key_pressed, 1'b1);
      if (cyc >= 0 && vecs[v].hold > cyc) tick(vecs[v].hold - cyc);
      keys[vecs[v].r] = 4'h0;
      wait_release(60, rc);
      check_release($sformatf("vec%0d_release", v), rc);
      tick(20);
      check($sformatf("vec%0d_pulses", v), pulses, 1);
    end

    // Press bounce on 'D'
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      keys[3] = (k % 2 == 0) ? 4'b1000 : 4'h0;
      tick(3);
    end
    tick(2);
    check("bounce_no_pulse", pulses, 0);
    keys[3] = 4'b1000;
    wait_valid(100, cyc);
    check("bounce_seen", (cyc >= 0), 1'b1);
    check("bounce_code", key_code, 4'hD);
    tick(10);
    keys[3] = 4'h0;
    wait_release(60, rc);
    check_release("bounce_release", rc);
    tick(20);
    check("bounce_pulses", pulses, 1);

    // Release bounce on '5'
    pulses = 0;
    kp_drop = 0;
    keys[1] = 4'b0010;
    wait_valid(100, cyc);
    check("relb_seen", (cyc >= 0), 1'b1);
    check("relb_code", key_code, 4'h5);
    tick(10);
    repeat (2) begin
      keys[1] = 4'h0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        if (!key_pressed) kp_drop++;
      end
      keys[1] = 4'b0010;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (!key_pressed) kp_drop++;
      end
    end
    check("relb_pressed_held", kp_drop, 0);
    keys[1] = 4'h0;
    wait_release(60, rc);
    check_release("relb_release", rc);
    tick(20);
    check("relb_pulses", pulses, 1);

    // Two keys in row 0: '1' wins, then '3' after '1' is released
    pulses = 0;
    keys[0] = 4'b0101;
    wait_valid(100, cyc);
    check("two_first_seen", (cyc >= 0), 1'b1);
    check("two_first_code", key_code, 4'h1);
    tick(10);
    keys[0] = 4'b0100;
    wait_valid(100, cyc);
    check("two_second_seen", (cyc >= 0), 1'b1);
    check("two_second_code", key_code, 4'h3);
    tick(5);
    keys[0] = 4'h0;
    wait_release(60, rc);
    check_release("two_release", rc);
    tick(20);
    check("two_pulses", pulses, 2);

    // Asynchronous reset clears outputs between clock edges
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_code", key_code, 4'h0);
    check("async_row", row, 4'b1110);
    check("async_pressed", key_pressed, 1'b0);

    // Reset four cycles into DEBOUNCE for 'A'
    keys[0] = 4'b1000;
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    tick(8);
    reset = 1'b0;
    tick(3);
    keys[0] = 4'h0;
    reset = 1'b1;
    tick(40);
    check("middeb_pulses", pulses, 0);
    check("middeb_code", key_code, 4'h0);

    check("no_back_to_back_valid", consec, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
